// File: rtl/spike_dispatcher_pkg.sv
// Shared definitions for the spike dispatcher: default widths, FSM state
// encoding and a small index-width helper used by the top and the arbiter.
package spike_dispatcher_pkg;

    localparam int unsigned AddrWDefault = 12;
    localparam int unsigned PtrWDefault  = 5;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StEmit = 1'b1
    } state_e;

    // Width needed to index n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_dispatcher_if.sv
// Outgoing packet port of the spike dispatcher (valid/ready handshake).
//   pkt_valid : packet valid, driven by the dispatcher
//   pkt_ready : downstream (NoC router port) accepts the packet
//   packet    : {origin[2*ADDR_W-1:ADDR_W], destination[ADDR_W-1:0]}
interface spike_dispatcher_if
    import spike_dispatcher_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault
) ();

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [2*ADDR_W-1:0]   packet;

    modport master (
        output pkt_valid,
        output packet,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  packet,
        output pkt_ready
    );

endinterface

// File: rtl/spike_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter over the pending-neuron vector.
//   req       : one request bit per neuron
//   rr_ptr    : highest-priority neuron index (always < NUM_NEURONS)
//   gnt_valid : at least one request is set
//   gnt_idx   : first requesting neuron at or after rr_ptr, wrapping
module spike_dispatcher_rr_arbiter
    import spike_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned IDX_W       = idx_width(NUM_NEURONS)
) (
    input  logic [NUM_NEURONS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic                   gnt_valid,
    output logic [IDX_W-1:0]       gnt_idx
);

    logic [NUM_NEURONS-1:0] req_rot;
    logic [IDX_W:0]         sum;

    always_comb begin
        // Rotate so that bit 0 is the neuron at rr_ptr.
        req_rot   = NUM_NEURONS'({req, req} >> rr_ptr);
        gnt_valid = |req_rot;
        gnt_idx   = '0;
        sum       = '0;
        // Walk downwards so the lowest rotated offset is the one that sticks.
        for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
                if (sum >= (IDX_W + 1)'(NUM_NEURONS)) begin
                    sum = sum - (IDX_W + 1)'(NUM_NEURONS);
                end
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spike_dispatcher.sv
// Spike dispatcher: captures rising spike edges from the neurons of one core,
// arbitrates between spiking neurons round-robin and walks each granted
// neuron's CSR connection list, emitting one {origin, destination} packet per
// downstream connection on the outgoing valid/ready port.
//   CLK, rst_n                  : clock, async active-low reset
//   clear                       : timestep-start pulse; sets overrun if busy
//   spikes                      : spike level per neuron
//   init_load                   : capture the init buses (IDLE, nothing pending)
//   neuron_addresses_init       : neuron i at [(N-i)*ADDR_W-1 -: ADDR_W]
//   connection_pointer_init     : ptr[i] at [(N+1-i)*PTR_W-1 -: PTR_W]
//   downstream_connections_init : conn[k] at [(MAX_CONN-k)*ADDR_W-1 -: ADDR_W]
//   pkt                         : outgoing packet port (master side)
//   busy                        : events pending or a list is being emitted
//   overrun                     : sticky, clear arrived while busy
module spike_dispatcher
    import spike_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ADDR_W      = AddrWDefault,
    parameter int unsigned PTR_W       = PtrWDefault,
    parameter int unsigned MAX_CONN    = 30
) (
    input  logic                             CLK,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [NUM_NEURONS-1:0]           spikes,
    input  logic                             init_load,
    input  logic [NUM_NEURONS*ADDR_W-1:0]    neuron_addresses_init,
    input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_init,
    input  logic [MAX_CONN*ADDR_W-1:0]       downstream_connections_init,
    spike_dispatcher_if.master               pkt,
    output logic                             busy,
    output logic                             overrun
);

    localparam int unsigned IdxW  = idx_width(NUM_NEURONS);
    localparam int unsigned PIdxW = idx_width(NUM_NEURONS + 1);
    localparam int unsigned CntW  = PTR_W + 1;
    // Lookup arrays are padded to a power of two so every index is in range.
    localparam int unsigned NAddr = 2 ** IdxW;
    localparam int unsigned NPtr  = 2 ** PIdxW;
    localparam int unsigned NConn = 2 ** PTR_W;

    state_e                           state_q, state_d;
    logic [NUM_NEURONS-1:0]           spikes_q;
    logic [NUM_NEURONS-1:0]           pending_q, pending_d;
    logic [IdxW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]                  cur_q, cur_d;
    logic [PTR_W-1:0]                 idx_q, idx_d;
    logic [PTR_W-1:0]                 end_ptr_q, end_ptr_d;
    logic                             pkt_valid_q, pkt_valid_d;
    logic [2*ADDR_W-1:0]              packet_q, packet_d;
    logic                             overrun_q, overrun_d;
    logic [NUM_NEURONS*ADDR_W-1:0]    addr_cfg_q, addr_cfg_d;
    logic [(NUM_NEURONS+1)*PTR_W-1:0] ptr_cfg_q, ptr_cfg_d;
    logic [MAX_CONN*ADDR_W-1:0]       conn_cfg_q, conn_cfg_d;

    logic [ADDR_W-1:0] addr_arr [NAddr];
    logic [PTR_W-1:0]  ptr_arr  [NPtr];
    logic [ADDR_W-1:0] conn_arr [NConn];

    logic                   gnt_valid;
    logic [IdxW-1:0]        gnt_idx;
    logic [PIdxW-1:0]       gnt_pidx;
    logic [PTR_W-1:0]       start_ptr, stop_ptr, idx_next;
    logic                   list_empty, list_last;
    logic [NUM_NEURONS-1:0] spike_rise, gnt_mask;

    // Unpack the flat configuration registers into lookup arrays.
    for (genvar i = 0; i < NAddr; i++) begin : g_addr
        if (i < NUM_NEURONS) begin : g_used
            assign addr_arr[i] = addr_cfg_q[(NUM_NEURONS-i)*ADDR_W-1 -: ADDR_W];
        end else begin : g_pad
            assign addr_arr[i] = '0;
        end
    end

    for (genvar i = 0; i < NPtr; i++) begin : g_ptr
        if (i < NUM_NEURONS + 1) begin : g_used
            assign ptr_arr[i] = ptr_cfg_q[(NUM_NEURONS+1-i)*PTR_W-1 -: PTR_W];
        end else begin : g_pad
            assign ptr_arr[i] = '0;
        end
    end

    for (genvar k = 0; k < NConn; k++) begin : g_conn
        if (k < MAX_CONN) begin : g_used
            assign conn_arr[k] = conn_cfg_q[(MAX_CONN-k)*ADDR_W-1 -: ADDR_W];
        end else begin : g_pad
            assign conn_arr[k] = '0;
        end
    end

    spike_dispatcher_rr_arbiter #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IdxW)
    ) u_arb (
        .req       (pending_q),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign spike_rise = spikes & ~spikes_q;
    assign gnt_pidx   = PIdxW'(gnt_idx);
    assign start_ptr  = ptr_arr[gnt_pidx];
    assign stop_ptr   = ptr_arr[gnt_pidx + PIdxW'(1)];
    // Out-of-order or out-of-table pointers mean the neuron has no connections.
    assign list_empty = ({1'b0, stop_ptr} <= {1'b0, start_ptr}) ||
                        ({1'b0, stop_ptr} > CntW'(MAX_CONN));
    assign list_last  = ({1'b0, idx_q} + CntW'(1)) == {1'b0, end_ptr_q};
    assign idx_next   = idx_q + PTR_W'(1);

    assign busy          = (pending_q != '0) || (state_q == StEmit);
    assign overrun       = overrun_q;
    assign pkt.pkt_valid = pkt_valid_q;
    assign pkt.packet    = packet_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        idx_d       = idx_q;
        end_ptr_d   = end_ptr_q;
        pkt_valid_d = pkt_valid_q;
        packet_d    = packet_q;
        overrun_d   = overrun_q;
        addr_cfg_d  = addr_cfg_q;
        ptr_cfg_d   = ptr_cfg_q;
        conn_cfg_d  = conn_cfg_q;
        gnt_mask    = '0;

        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    gnt_mask  = NUM_NEURONS'(1) << gnt_idx;
                    rr_ptr_d  = (gnt_idx == IdxW'(NUM_NEURONS - 1)) ? '0 : gnt_idx + IdxW'(1);
                    cur_d     = gnt_idx;
                    idx_d     = start_ptr;
                    end_ptr_d = stop_ptr;
                    if (!list_empty) begin
                        state_d     = StEmit;
                        pkt_valid_d = 1'b1;
                        packet_d    = {addr_arr[gnt_idx], conn_arr[start_ptr]};
                    end
                end else if (init_load) begin
                    addr_cfg_d = neuron_addresses_init;
                    ptr_cfg_d  = connection_pointer_init;
                    conn_cfg_d = downstream_connections_init;
                    overrun_d  = 1'b0;
                end
            end
            StEmit: begin
                if (pkt.pkt_ready) begin
                    if (list_last) begin
                        state_d     = StIdle;
                        pkt_valid_d = 1'b0;
                    end else begin
                        // Next packet is loaded on the accepting edge: no bubble.
                        idx_d    = idx_next;
                        packet_d = {addr_arr[cur_q], conn_arr[idx_next]};
                    end
                end
            end
            default: begin
                state_d     = StIdle;
                pkt_valid_d = 1'b0;
            end
        endcase

        if (clear && busy) begin
            overrun_d = 1'b1;
        end

        // A new edge wins over the grant clearing the same bit.
        pending_d = (pending_q & ~gnt_mask) | spike_rise;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            spikes_q    <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            idx_q       <= '0;
            end_ptr_q   <= '0;
            pkt_valid_q <= 1'b0;
            packet_q    <= '0;
            overrun_q   <= 1'b0;
            addr_cfg_q  <= '0;
            ptr_cfg_q   <= '0;
            conn_cfg_q  <= '0;
        end else begin
            state_q     <= state_d;
            spikes_q    <= spikes;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            idx_q       <= idx_d;
            end_ptr_q   <= end_ptr_d;
            pkt_valid_q <= pkt_valid_d;
            packet_q    <= packet_d;
            overrun_q   <= overrun_d;
            addr_cfg_q  <= addr_cfg_d;
            ptr_cfg_q   <= ptr_cfg_d;
            conn_cfg_q  <= conn_cfg_d;
        end
    end

endmodule

// File: tb/tb_spike_dispatcher.sv
module tb_spike_dispatcher;

    localparam int unsigned N  = 10;
    localparam int unsigned AW = 12;
    localparam int unsigned PW = 5;
    localparam int unsigned MC = 30;

    typedef logic [2*AW-1:0] pkt_t;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              init_load;
    logic              ready;
    logic [N-1:0]      spikes;
    logic [N*AW-1:0]   addr_bus;
    logic [(N+1)*PW-1:0] ptr_bus;
    logic [MC*AW-1:0]  conn_bus;
    logic              busy;
    logic              overrun;

    spike_dispatcher_if #(.ADDR_W(AW)) pkt_if ();
    assign pkt_if.pkt_ready = ready;

    spike_dispatcher #(
        .NUM_NEURONS (N),
        .ADDR_W      (AW),
        .PTR_W       (PW),
        .MAX_CONN    (MC)
    ) dut (
        .CLK                         (CLK),
        .rst_n                       (rst_n),
        .clear                       (clear),
        .spikes                      (spikes),
        .init_load                   (init_load),
        .neuron_addresses_init       (addr_bus),
        .connection_pointer_init     (ptr_bus),
        .downstream_connections_init (conn_bus),
        .pkt                         (pkt_if),
        .busy                        (busy),
        .overrun                     (overrun)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Staged configuration (drives the init buses) and the model's loaded copy.
    int unsigned cfg_addr [N];
    int unsigned cfg_ptr  [N+1];
    int unsigned cfg_conn [MC];
    int unsigned m_addr   [N];
    int unsigned m_ptr    [N+1];
    int unsigned m_conn   [MC];

    logic [N-1:0] m_pending;
    logic [N-1:0] m_prev;
    int unsigned  m_rr;
    bit           m_ovr;
    pkt_t         m_q [$];   // packets still to be emitted for the granted neuron
    pkt_t         acc [$];   // packets the DUT handed over
    pkt_t         exp_q [$];
    int           edge_n;

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) addr_bus[(N-i)*AW-1 -: AW] = AW'(cfg_addr[i]);
        for (int i = 0; i < N + 1; i++) ptr_bus[(N+1-i)*PW-1 -: PW] = PW'(cfg_ptr[i]);
        for (int k = 0; k < MC; k++) conn_bus[(MC-k)*AW-1 -: AW] = AW'(cfg_conn[k]);
    endtask

    task automatic default_cfg();
        int unsigned p [N+1] = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
        int unsigned c [19]  = '{3, 5, 7, 4, 6, 4, 5, 6, 8, 9, 8, 9, 8, 9, 9, 8, 9, 'hFFB, 'hFFC};
        for (int i = 0; i < N; i++) cfg_addr[i] = i;
        for (int i = 0; i < N + 1; i++) cfg_ptr[i] = p[i];
        for (int k = 0; k < MC; k++) cfg_conn[k] = (k < 19) ? c[k] : 0;
        apply_cfg();
    endtask

    task automatic random_cfg();
        for (int i = 0; i < N; i++) cfg_addr[i] = $urandom_range(0, 4095);
        cfg_ptr[0] = $urandom_range(0, 3);
        for (int i = 1; i < N + 1; i++) begin
            cfg_ptr[i] = cfg_ptr[i-1] + $urandom_range(0, 3);
            if (cfg_ptr[i] > 31) cfg_ptr[i] = 31;
        end
        if ($urandom_range(0, 3) == 0) cfg_ptr[$urandom_range(0, N)] = $urandom_range(0, 31);
        for (int k = 0; k < MC; k++) cfg_conn[k] = $urandom_range(0, 4095);
        apply_cfg();
    endtask

    task automatic model_reset();
        m_pending = '0;
        m_prev    = '0;
        m_rr      = 0;
        m_ovr     = 1'b0;
        m_q.delete();
        for (int i = 0; i < N; i++) m_addr[i] = 0;
        for (int i = 0; i < N + 1; i++) m_ptr[i] = 0;
        for (int k = 0; k < MC; k++) m_conn[k] = 0;
    endtask

    // One clock edge of the dispatcher, as a list-of-packets machine.
    task automatic model_edge();
        bit busy_pre;
        int g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        busy_pre = (m_pending != '0) || (m_q.size() != 0);
        if (clear && busy_pre) m_ovr = 1'b1;
        if (m_q.size() != 0) begin
            if (ready) void'(m_q.pop_front());
        end else if (m_pending != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (g < 0 && m_pending[c]) g = c;
            end
            m_pending[g] = 1'b0;
            m_rr = (g + 1) % N;
            if (m_ptr[g+1] > m_ptr[g] && m_ptr[g+1] <= MC) begin
                for (int unsigned j = m_ptr[g]; j < m_ptr[g+1]; j++) begin
                    m_q.push_back({AW'(m_addr[g]), AW'(m_conn[j])});
                end
            end
        end else if (init_load) begin
            m_addr = cfg_addr;
            m_ptr  = cfg_ptr;
            m_conn = cfg_conn;
            m_ovr  = 1'b0;
        end
        m_pending = m_pending | (spikes & ~m_prev);
        m_prev    = spikes;
    endtask

    task automatic cycle();
        if (pkt_if.pkt_valid === 1'b1 && ready) acc.push_back(pkt_if.packet);
        @(posedge CLK);
        edge_n++;
        model_edge();
        @(negedge CLK);
        check_eq("pkt_valid", 64'(pkt_if.pkt_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check_eq("packet", 64'(pkt_if.packet), 64'(m_q[0]));
        check_eq("busy", 64'(busy), 64'((m_pending != '0) || (m_q.size() != 0)));
        check_eq("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_seq(input string tag, input pkt_t exp [$]);
        check_eq({tag, "_count"}, 64'(acc.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < acc.size(); i++) begin
            check_eq($sformatf("%s_%0d", tag, i), 64'(acc[i]), 64'(exp[i]));
        end
    endtask

    task automatic load_cfg();
        init_load = 1'b1;
        run(1);
        init_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int ev;
        rst_n     = 1'b0;
        clear     = 1'b0;
        init_load = 1'b0;
        ready     = 1'b1;
        spikes    = '0;
        edge_n    = 0;
        default_cfg();
        model_reset();
        #1;
        check_eq("rst_pkt_valid", 64'(pkt_if.pkt_valid), 64'(0));
        check_eq("rst_packet", 64'(pkt_if.packet), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_overrun", 64'(overrun), 64'(0));
        run(2);
        rst_n = 1'b1;
        run(2);
        load_cfg();
        run(1);

        // Neuron 0: three packets, valid one edge after the capturing edge.
        acc.delete();
        spikes[0] = 1'b1;
        e0 = edge_n + 1;
        run(1);
        spikes = '0;
        ev = -1;
        for (int k = 0; k < 8 && ev < 0; k++) begin
            if (pkt_if.pkt_valid === 1'b1) ev = edge_n;
            else run(1);
        end
        check_eq("spk0_latency", 64'(ev - e0), 64'(1));
        run(6);
        exp_q = '{24'h000003, 24'h000005, 24'h000007};
        check_seq("spk0", exp_q);
        check_eq("spk0_idle_busy", 64'(busy), 64'(0));

        // Two neurons in the same cycle, then a wrap of the round-robin pointer.
        acc.delete();
        spikes = N'((1 << 1) | (1 << 8));
        run(1);
        spikes = '0;
        run(10);
        exp_q = '{24'h001004, 24'h001006, 24'h008FFB};
        check_seq("rr_1_8", exp_q);
        acc.delete();
        spikes = N'((1 << 1) | (1 << 2));
        run(1);
        spikes = '0;
        run(12);
        exp_q = '{24'h001004, 24'h001006, 24'h002004, 24'h002005, 24'h002006};
        check_seq("rr_wrap", exp_q);

        // Backpressure: packet held for five cycles, accepted once.
        acc.delete();
        spikes[9] = 1'b1;
        ready = 1'b0;
        run(1);
        spikes = '0;
        run(5);
        check_eq("hold_valid", 64'(pkt_if.pkt_valid), 64'(1));
        check_eq("hold_packet", 64'(pkt_if.packet), 64'(24'h009FFC));
        ready = 1'b1;
        run(1);
        check_eq("hold_drop", 64'(pkt_if.pkt_valid), 64'(0));
        run(2);
        exp_q = '{24'h009FFC};
        check_seq("hold", exp_q);

        // Empty list (neuron 3) and malformed pointers (neuron 5).
        cfg_ptr[4] = 8;
        cfg_ptr[6] = 31;
        apply_cfg();
        load_cfg();
        acc.delete();
        spikes[3] = 1'b1;
        run(1);
        spikes = '0;
        run(1);
        check_eq("empty_busy", 64'(busy), 64'(0));
        spikes[5] = 1'b1;
        run(1);
        spikes = '0;
        run(1);
        check_eq("malformed_busy", 64'(busy), 64'(0));
        run(3);
        check_eq("empty_no_pkts", 64'(acc.size()), 64'(0));
        default_cfg();
        load_cfg();

        // clear during emission flags overrun; the list still completes.
        acc.delete();
        spikes[0] = 1'b1;
        run(1);
        spikes = '0;
        run(1);
        clear = 1'b1;
        run(1);
        clear = 1'b0;
        check_eq("overrun_set", 64'(overrun), 64'(1));
        run(5);
        exp_q = '{24'h000003, 24'h000005, 24'h000007};
        check_seq("clear_emit", exp_q);
        load_cfg();
        check_eq("overrun_cleared", 64'(overrun), 64'(0));

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            spikes    = ($urandom_range(0, 31) == 0) ? N'($urandom) : '0;
            ready     = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 15) == 0);
            init_load = ($urandom_range(0, 11) == 0);
            if (init_load) random_cfg();
            run(1);
        end
        spikes    = '0;
        clear     = 1'b0;
        init_load = 1'b0;
        ready     = 1'b1;
        for (int k = 0; k < 400 && busy !== 1'b0; k++) run(1);
        check_eq("drain", 64'(busy), 64'(0));

        // Asynchronous reset in the middle of a list.
        default_cfg();
        load_cfg();
        spikes[0] = 1'b1;
        run(1);
        spikes = '0;
        run(1);
        check_eq("pre_rst_valid", 64'(pkt_if.pkt_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(pkt_if.pkt_valid), 64'(0));
        check_eq("async_rst_packet", 64'(pkt_if.packet), 64'(0));
        model_reset();
        run(1);
        rst_n = 1'b1;
        run(5);
        check_eq("post_rst_valid", 64'(pkt_if.pkt_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
